// File: rtl/pipe_stage_skid.sv
// Generic MIPS5 pipeline stage: valid/ready handshake, 2-entry skid buffer,
// flush-to-bubble with per-bit retention of the incoming word.
module pipe_stage_skid #(
  parameter int unsigned      WIDTH           = 64,
  parameter logic [WIDTH-1:0] NOP_VAL         = '0,
  parameter logic [WIDTH-1:0] RST_VAL         = NOP_VAL,
  parameter logic [WIDTH-1:0] KEEP_MASK       = '0,
  parameter bit               BUBBLE_ON_DRAIN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             out_valid_d, in_ready_d;
  logic [1:0]       occupancy_d;
  logic             push, pop;

  assign push     = in_valid & in_ready & ~flush;
  assign pop      = out_valid & out_ready & ~flush;
  assign out_data = main_q;

  // State, payload and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      main_q    <= RST_VAL;
      skid_q    <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      occupancy <= 2'd0;
    end else begin
      state     <= state_d;
      main_q    <= main_d;
      skid_q    <= skid_d;
      out_valid <= out_valid_d;
      in_ready  <= in_ready_d;
      occupancy <= occupancy_d;
    end
  end

  // Next state and payload; flush overrides every other event.
  always_comb begin
    state_d = state;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = (in_data & KEEP_MASK) | (NOP_VAL & ~KEEP_MASK);
      skid_d  = '0;
    end else begin
      unique case (state)
        EMPTY: begin
          if (push) begin
            state_d = ONE;
            main_d  = in_data;
          end
        end
        ONE: begin
          if (push && pop) begin
            main_d = in_data;
          end else if (push) begin
            state_d = FULL;
            skid_d  = in_data;
          end else if (pop) begin
            state_d = EMPTY;
            if (BUBBLE_ON_DRAIN) main_d = NOP_VAL;
          end
        end
        FULL: begin
          if (pop) begin
            state_d = ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Handshake outputs are precomputed from the next state so they leave a flop.
  always_comb begin
    out_valid_d = 1'b0;
    in_ready_d  = 1'b1;
    occupancy_d = 2'd0;
    unique case (state_d)
      ONE: begin
        out_valid_d = 1'b1;
        occupancy_d = 2'd1;
      end
      FULL: begin
        out_valid_d = 1'b1;
        in_ready_d  = 1'b0;
        occupancy_d = 2'd2;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed and reference-FIFO checks for pipe_stage_skid with IF/ID parameters.
module tb_pipe_stage_skid;

  localparam int unsigned W            = 64;
  localparam logic [31:0] DEFAULT_PC_4 = 32'hBFC0_0004;
  localparam logic [31:0] INST_NOP     = 32'h0000_0000;
  localparam logic [W-1:0] NOP_V       = {DEFAULT_PC_4, INST_NOP};
  localparam logic [W-1:0] KEEP_V      = {32'hFFFF_FFFF, 32'h0000_0000};

  logic         clk;
  logic         rst_n;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [1:0]   occupancy;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] q[$];
  logic [W-1:0] bub;
  logic [W-1:0] exp_data;
  logic         m_push, m_pop;

  pipe_stage_skid #(
    .WIDTH(W), .NOP_VAL(NOP_V), .RST_VAL(NOP_V), .KEEP_MASK(KEEP_V), .BUBBLE_ON_DRAIN(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic chk_state(input string tag, input logic ov, input logic ir,
                           input logic [1:0] occ, input logic [W-1:0] d);
    chk({tag, "_out_valid"}, W'(out_valid), W'(ov));
    chk({tag, "_in_ready"},  W'(in_ready),  W'(ir));
    chk({tag, "_occupancy"}, W'(occupancy), W'(occ));
    chk({tag, "_out_data"},  out_data,      d);
  endtask

  initial begin
    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;

    // Reset: asynchronous, before any clock edge.
    #2 rst_n = 1'b0;
    #2 chk_state("reset", 1'b0, 1'b1, 2'd0, NOP_V);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk_state("post_reset", 1'b0, 1'b1, 2'd0, NOP_V);

    // Stream 1..8 with out_ready=1: one cycle latency, occupancy stays 1.
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = W'(i);
      tick();
      chk_state("stream", 1'b1, 1'b1, 2'd1, W'(i));
    end
    in_valid = 1'b0;
    tick();
    chk_state("drain_bubble", 1'b0, 1'b1, 2'd0, NOP_V);

    // Fill to FULL with out_ready=0, then deliver A then B.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'hAAAA_0000_0000_000A;
    tick();
    chk_state("fill_a", 1'b1, 1'b1, 2'd1, 64'hAAAA_0000_0000_000A);
    in_data = 64'hBBBB_0000_0000_000B;
    tick();
    chk_state("fill_b", 1'b1, 1'b0, 2'd2, 64'hAAAA_0000_0000_000A);
    in_data = 64'hCCCC_0000_0000_000C;
    tick();
    chk_state("full_hold", 1'b1, 1'b0, 2'd2, 64'hAAAA_0000_0000_000A);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk_state("deliver_b", 1'b1, 1'b1, 2'd1, 64'hBBBB_0000_0000_000B);
    tick();
    chk_state("deliver_empty", 1'b0, 1'b1, 2'd0, NOP_V);

    // Flush in FULL keeps pc_4 from in_data and replaces inst with NOP.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'h1111_0000_0000_0001;
    tick();
    in_data = 64'h2222_0000_0000_0002;
    tick();
    chk_state("refill", 1'b1, 1'b0, 2'd2, 64'h1111_0000_0000_0001);
    flush   = 1'b1;
    in_data = {32'h0000_0044, 32'h1234_5678};
    tick();
    chk_state("flush_full", 1'b0, 1'b1, 2'd0, {32'h0000_0044, INST_NOP});
    flush    = 1'b0;
    in_valid = 1'b0;
    tick();
    chk_state("flush_settle", 1'b0, 1'b1, 2'd0, {32'h0000_0044, INST_NOP});

    // Push, pop and flush together in ONE: flush wins and the word is dropped.
    in_valid = 1'b1;
    in_data  = 64'h0000_00D0_0000_00DD;
    tick();
    chk_state("one_d", 1'b1, 1'b1, 2'd1, 64'h0000_00D0_0000_00DD);
    out_ready = 1'b1;
    flush     = 1'b1;
    in_data   = 64'hAAAA_0001_5555_0002;
    tick();
    chk_state("flush_one", 1'b0, 1'b1, 2'd0, {32'hAAAA_0001, INST_NOP});
    flush    = 1'b0;
    in_valid = 1'b0;
    tick();
    chk_state("flush_drop", 1'b0, 1'b1, 2'd0, {32'hAAAA_0001, INST_NOP});

    // Random traffic against a reference FIFO, with a mid-run async reset.
    q.delete();
    bub = {32'hAAAA_0001, INST_NOP};
    for (int i = 0; i < 10000; i++) begin
      if (i == 5000) begin
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk_state("mid_reset", 1'b0, 1'b1, 2'd0, NOP_V);
        tick();
        rst_n = 1'b1;
        q.delete();
        bub = NOP_V;
        tick();
        chk_state("mid_reset_release", 1'b0, 1'b1, 2'd0, NOP_V);
      end
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      flush     = ($urandom_range(0, 19) == 0);
      in_data   = {$urandom, $urandom};
      m_push = in_valid && (q.size() < 2) && !flush;
      m_pop  = (q.size() > 0) && out_ready && !flush;
      tick();
      if (flush) begin
        q.delete();
        bub = (in_data & KEEP_V) | (NOP_V & ~KEEP_V);
      end else begin
        if (m_pop) void'(q.pop_front());
        if (m_push) q.push_back(in_data);
        if (m_pop && q.size() == 0) bub = NOP_V;
      end
      exp_data = (q.size() > 0) ? q[0] : bub;
      chk_state("random", q.size() > 0, q.size() < 2, 2'(q.size()), exp_data);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
